// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Latches decoded operands and control, detects
// load-use hazards against the instruction already in EX, inserts a one-cycle
// bubble with a PC/IF-ID freeze, and bypasses same-cycle write-back data into
// the latched operands.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ip_flush,
    input  logic              ip_DEC_valid,
    input  logic [REG_W-1:0]  ip_DEC_rs,
    input  logic [REG_W-1:0]  ip_DEC_rt,
    input  logic [REG_W-1:0]  ip_DEC_rd,
    input  logic [DATA_W-1:0] ip_DEC_rs_data,
    input  logic [DATA_W-1:0] ip_DEC_rt_data,
    input  logic [DATA_W-1:0] ip_DEC_imm,
    input  logic [7:0]        ip_DEC_ctrl,
    input  logic              ip_WB_RegWrite,
    input  logic [REG_W-1:0]  ip_WB_dest,
    input  logic [DATA_W-1:0] ip_WB_data,
    output logic              op_EX_valid,
    output logic [REG_W-1:0]  op_EX_rs,
    output logic [REG_W-1:0]  op_EX_rt,
    output logic [REG_W-1:0]  op_EX_dest,
    output logic [DATA_W-1:0] op_EX_rs_data,
    output logic [DATA_W-1:0] op_EX_rt_data,
    output logic [DATA_W-1:0] op_EX_imm,
    output logic [7:0]        op_EX_ctrl,
    output logic              op_stall,
    output logic [CNT_W-1:0]  op_stall_cnt
);

    // One EX slot; an all-zero record is a bubble (indices at r0 never forward).
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [7:0]        ctrl;
    } ex_t;

    ex_t              ex_q;
    ex_t              ex_load;
    logic             uses_rt;
    logic             load_use;
    logic             bypass_rs;
    logic             bypass_rt;
    logic [CNT_W-1:0] cnt_q;

    // Hazard detect: a load in EX whose target is read by the decode instruction.
    // Immediate-form ALU ops do not read Rt, but stores do.
    always_comb begin
        uses_rt  = ~ip_DEC_ctrl[4] | ip_DEC_ctrl[2];
        load_use = ex_q.valid & ex_q.ctrl[1] & (ex_q.rt != '0) & ip_DEC_valid
                 & ((ex_q.rt == ip_DEC_rs) | (uses_rt & (ex_q.rt == ip_DEC_rt)));
        op_stall = load_use & ~ip_flush;
    end

    // Normal-load record, with the regfile read bypassed by a same-cycle WB write.
    always_comb begin
        bypass_rs       = ip_WB_RegWrite & (ip_WB_dest != '0) & (ip_WB_dest == ip_DEC_rs);
        bypass_rt       = ip_WB_RegWrite & (ip_WB_dest != '0) & (ip_WB_dest == ip_DEC_rt);
        ex_load         = '0;
        ex_load.valid   = ip_DEC_valid;
        ex_load.rs      = ip_DEC_rs;
        ex_load.rt      = ip_DEC_rt;
        ex_load.dest    = ip_DEC_ctrl[5] ? ip_DEC_rd : ip_DEC_rt;
        ex_load.rs_data = bypass_rs ? ip_WB_data : ip_DEC_rs_data;
        ex_load.rt_data = bypass_rt ? ip_WB_data : ip_DEC_rt_data;
        ex_load.imm     = ip_DEC_imm;
        ex_load.ctrl    = ip_DEC_valid ? ip_DEC_ctrl : 8'h00;
    end

    // Stage register: reset beats flush beats load-use bubble beats normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (ip_flush) begin
            ex_q  <= '0;
        end else if (load_use) begin
            ex_q  <= '0;
            if (cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            ex_q  <= ex_load;
        end
    end

    assign op_EX_valid   = ex_q.valid;
    assign op_EX_rs      = ex_q.rs;
    assign op_EX_rt      = ex_q.rt;
    assign op_EX_dest    = ex_q.dest;
    assign op_EX_rs_data = ex_q.rs_data;
    assign op_EX_rt_data = ex_q.rt_data;
    assign op_EX_imm     = ex_q.imm;
    assign op_EX_ctrl    = ex_q.ctrl;
    assign op_stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard/bypass/flush scenarios followed by
// randomized traffic, all checked against a behavioural model of the EX slot.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, dvalid, wbw;
    logic [4:0]  drs, drt, drd, wbd;
    logic [31:0] drsd, drtd, dimm, wbdata;
    logic [7:0]  dctrl;

    logic        ex_valid, ex2_valid, stall, stall2;
    logic [4:0]  ex_rs, ex_rt, ex_dest, ex2_rs, ex2_rt, ex2_dest;
    logic [31:0] ex_rsd, ex_rtd, ex_imm, ex2_rsd, ex2_rtd, ex2_imm;
    logic [7:0]  ex_ctrl, ex2_ctrl;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model of the EX slot plus an unbounded bubble tally.
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [7:0]  m_ctrl;
    int          m_bubbles;
    logic        obs_stall;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .ip_flush(flush), .ip_DEC_valid(dvalid),
        .ip_DEC_rs(drs), .ip_DEC_rt(drt), .ip_DEC_rd(drd),
        .ip_DEC_rs_data(drsd), .ip_DEC_rt_data(drtd), .ip_DEC_imm(dimm),
        .ip_DEC_ctrl(dctrl), .ip_WB_RegWrite(wbw), .ip_WB_dest(wbd), .ip_WB_data(wbdata),
        .op_EX_valid(ex_valid), .op_EX_rs(ex_rs), .op_EX_rt(ex_rt), .op_EX_dest(ex_dest),
        .op_EX_rs_data(ex_rsd), .op_EX_rt_data(ex_rtd), .op_EX_imm(ex_imm),
        .op_EX_ctrl(ex_ctrl), .op_stall(stall), .op_stall_cnt(cnt)
    );

    // Narrow counter instance to exercise saturation.
    id_ex_stage_reg #(.DATA_W(32), .REG_W(5), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .ip_flush(flush), .ip_DEC_valid(dvalid),
        .ip_DEC_rs(drs), .ip_DEC_rt(drt), .ip_DEC_rd(drd),
        .ip_DEC_rs_data(drsd), .ip_DEC_rt_data(drtd), .ip_DEC_imm(dimm),
        .ip_DEC_ctrl(dctrl), .ip_WB_RegWrite(wbw), .ip_WB_dest(wbd), .ip_WB_data(wbdata),
        .op_EX_valid(ex2_valid), .op_EX_rs(ex2_rs), .op_EX_rt(ex2_rt), .op_EX_dest(ex2_dest),
        .op_EX_rs_data(ex2_rsd), .op_EX_rt_data(ex2_rtd), .op_EX_imm(ex2_imm),
        .op_EX_ctrl(ex2_ctrl), .op_stall(stall2), .op_stall_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The decode instruction must wait if the EX load targets a register it reads.
    function automatic logic model_stall();
        logic reads_rt;
        reads_rt = !dctrl[4] || dctrl[2];
        return m_valid && m_ctrl[1] && m_rt != 0 && dvalid && !flush &&
               (m_rt == drs || (reads_rt && m_rt == drt));
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rs = 0; m_rt = 0; m_dest = 0;
        m_rsd = 0; m_rtd = 0; m_imm = 0; m_ctrl = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_edge(input logic stall_now);
        if (rst) begin
            model_clear();
            m_bubbles = 0;
        end else if (flush) begin
            model_clear();
        end else if (stall_now) begin
            model_clear();
            m_bubbles++;
        end else begin
            m_valid = dvalid;
            m_ctrl  = dvalid ? dctrl : 8'h00;
            m_rs    = drs;
            m_rt    = drt;
            m_dest  = dctrl[5] ? drd : drt;
            m_rsd   = (wbw && wbd != 0 && wbd == drs) ? wbdata : drsd;
            m_rtd   = (wbw && wbd != 0 && wbd == drt) ? wbdata : drtd;
            m_imm   = dimm;
        end
    endtask

    task automatic check_regs();
        chk("valid",   32'(ex_valid), 32'(m_valid));
        chk("rs",      32'(ex_rs),    32'(m_rs));
        chk("rt",      32'(ex_rt),    32'(m_rt));
        chk("dest",    32'(ex_dest),  32'(m_dest));
        chk("rs_data", ex_rsd,        m_rsd);
        chk("rt_data", ex_rtd,        m_rtd);
        chk("imm",     ex_imm,        m_imm);
        chk("ctrl",    32'(ex_ctrl),  32'(m_ctrl));
        chk("cnt16",   32'(cnt),      32'((m_bubbles > 65535) ? 65535 : m_bubbles));
        chk("cnt2",    32'(cnt2),     32'((m_bubbles > 3) ? 3 : m_bubbles));
        chk("dut2_slot", {ex2_valid, ex2_rs, ex2_rt, ex2_dest, ex2_ctrl, 5'd0} ^ ex2_rsd ^ ex2_rtd ^ ex2_imm,
                         {ex_valid, ex_rs, ex_rt, ex_dest, ex_ctrl, 5'd0} ^ ex_rsd ^ ex_rtd ^ ex_imm);
    endtask

    // One clock: check the combinational stall mid-cycle, then the registered state.
    task automatic cycle();
        logic exp_stall;
        @(negedge clk);
        exp_stall = model_stall();
        obs_stall = stall;
        chk("stall",  32'(stall),  32'(exp_stall));
        chk("stall2", 32'(stall2), 32'(exp_stall));
        @(posedge clk);
        model_edge(exp_stall);
        #1;
        check_regs();
    endtask

    task automatic rand_inputs(input int span);
        flush  = ($urandom_range(7) == 0);
        dvalid = ($urandom_range(5) != 0);
        drs    = 5'($urandom_range(span));
        drt    = 5'($urandom_range(span));
        drd    = 5'($urandom_range(span));
        drsd   = $urandom;
        drtd   = $urandom;
        dimm   = $urandom;
        dctrl  = 8'($urandom);
        if ($urandom_range(2) == 0) dctrl[1] = 1'b1;
        wbw    = $urandom_range(1) == 1;
        wbd    = 5'($urandom_range(span));
        wbdata = $urandom;
    endtask

    task automatic decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [7:0] ctrl);
        dvalid = 1; drs = rs; drt = rt; drd = rd; dctrl = ctrl;
        drsd = 32'h1000_0000 | 32'(rs); drtd = 32'h2000_0000 | 32'(rt); dimm = 32'h0000_0040;
    endtask

    initial begin
        model_clear();
        m_bubbles = 0;
        obs_stall = 0;
        // Reset held two cycles under random inputs.
        rst = 1;
        rand_inputs(31);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs(31);
            cycle();
        end
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_cnt",   32'(cnt),      32'd0);
        rst = 0; flush = 0; wbw = 0; wbd = 0; wbdata = 0;

        // lw r8 in EX, add reading r8 in decode: one bubble then the add.
        decode(5'd1, 5'd8, 5'd0, 8'h1B);
        cycle();
        decode(5'd8, 5'd9, 5'd10, 8'h21);
        cycle();
        chk("t2_stall", 32'(obs_stall), 32'd1);
        chk("t2_bubble_valid", 32'(ex_valid), 32'd0);
        chk("t2_cnt", 32'(cnt), 32'd1);
        cycle();
        chk("t2_stall_after", 32'(obs_stall), 32'd0);
        chk("t2_add_rs", 32'(ex_rs), 32'd8);

        // Load to r0 never stalls; addi does not read Rt, sw does.
        decode(5'd3, 5'd0, 5'd0, 8'h1B);
        cycle();
        decode(5'd0, 5'd4, 5'd0, 8'h21);
        cycle();
        chk("t3_r0_stall", 32'(obs_stall), 32'd0);
        decode(5'd3, 5'd9, 5'd0, 8'h1B);
        cycle();
        decode(5'd2, 5'd9, 5'd0, 8'h11);
        cycle();
        chk("t3_addi_stall", 32'(obs_stall), 32'd0);
        decode(5'd3, 5'd9, 5'd0, 8'h1B);
        cycle();
        decode(5'd2, 5'd9, 5'd0, 8'h14);
        cycle();
        chk("t3_sw_stall", 32'(obs_stall), 32'd1);
        cycle();

        // WB bypass of both operands, then a write to r0 that must not bypass.
        decode(5'd5, 5'd5, 5'd6, 8'h21);
        drsd = 32'h1; drtd = 32'h1;
        wbw = 1; wbd = 5'd5; wbdata = 32'hDEADBEEF;
        cycle();
        chk("t4_rsd_bypass", ex_rsd, 32'hDEADBEEF);
        chk("t4_rtd_bypass", ex_rtd, 32'hDEADBEEF);
        wbd = 5'd0;
        cycle();
        chk("t4_rsd_r0", ex_rsd, 32'h1);
        chk("t4_rtd_r0", ex_rtd, 32'h1);
        wbw = 0;

        // Load-use coinciding with a flush: no stall, bubble, count unchanged.
        decode(5'd1, 5'd8, 5'd0, 8'h1B);
        cycle();
        decode(5'd8, 5'd9, 5'd10, 8'h21);
        flush = 1;
        cycle();
        chk("t5_stall", 32'(obs_stall), 32'd0);
        chk("t5_valid", 32'(ex_valid), 32'd0);
        chk("t5_cnt", 32'(cnt), 32'd2);
        flush = 0;

        // Saturation of the 2-bit counter after a fresh reset.
        rst = 1;
        cycle();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] want;
            decode(5'd1, 5'd8, 5'd0, 8'h1B);
            cycle();
            decode(5'd8, 5'd9, 5'd10, 8'h21);
            cycle();
            want = (i < 3) ? 2'(i + 1) : 2'd3;
            chk("t6_cnt2_sat", 32'(cnt2), 32'(want));
        end

        // Random traffic with small register indices to provoke hazards and bypasses.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(7);
            rst = ($urandom_range(49) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
